// File: rtl/instruction_fifo_if.sv
// Handshake bundle between the instruction decoder (push side), the GPU (pop side)
// and the instruction FIFO; the master modport is the producer/consumer view.
interface instruction_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [3:0]        in_opcode;
    logic [13:0]       in_register;
    logic [31:0]       in_data;
    logic              rd_en;
    logic [3:0]        out_opcode;
    logic [13:0]       out_register;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   level;
    logic              overflow;

    modport master (
        output wr_en, in_opcode, in_register, in_data, rd_en,
        input  out_opcode, out_register, out_data, out_valid,
        input  empty, full, level, overflow
    );

    modport slave (
        input  wr_en, in_opcode, in_register, in_data, rd_en,
        output out_opcode, out_register, out_data, out_valid,
        output empty, full, level, overflow
    );
endinterface

// File: rtl/instruction_fifo.sv
// Decoded-instruction FIFO between the decoder and the GPU: 50-bit entries,
// registered head output with a one-cycle out_valid pulse and a sticky overflow flag.
module instruction_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_en,
    instruction_fifo_if.slave    bus
);
    localparam int ENTRY_W = 50;

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]    level_reg, level_next;
    logic [ENTRY_W-1:0] out_reg;
    logic               out_valid_reg;
    logic               overflow_reg;

    logic empty;
    logic full;
    logic pop_acc;
    logic push_acc;
    logic push_drop;

    assign empty = (level_reg == '0);
    assign full  = (level_reg == (ADDR_W+1)'(DEPTH));

    // A pop frees a slot in the same edge, so a full FIFO still accepts a push
    // when the GPU drains one entry at the same time.
    assign pop_acc   = clk_en && bus.rd_en && !empty;
    assign push_acc  = clk_en && bus.wr_en && (!full || pop_acc);
    assign push_drop = clk_en && bus.wr_en && full && !pop_acc;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        if (push_acc) begin
            wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
        end
        if (pop_acc) begin
            rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
        end
        if (push_acc && !pop_acc) begin
            level_next = level_reg + (ADDR_W+1)'(1);
        end else if (pop_acc && !push_acc) begin
            level_next = level_reg - (ADDR_W+1)'(1);
        end
    end

    // Storage is left uncleared by reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr_reg] <= {bus.in_opcode, bus.in_register, bus.in_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            level_reg     <= level_next;
            out_valid_reg <= pop_acc;
            if (pop_acc) begin
                out_reg <= mem[rd_ptr_reg];
            end
            if (push_drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign bus.out_opcode   = out_reg[49:46];
    assign bus.out_register = out_reg[45:32];
    assign bus.out_data     = out_reg[31:0];
    assign bus.out_valid    = out_valid_reg;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.level        = level_reg;
    assign bus.overflow     = overflow_reg;
endmodule
